// File: rtl/sec_array_wr_stage_if.sv
// Request/write bus between an upstream requester and the array write-staging stage.
// master = requester/array-side driver, slave = the staging stage itself.
interface sec_array_wr_stage_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [IDX_W-1:0]  req_idx;
    logic [DATA_W-1:0] req_data;
    logic              req_idx_hi;
    logic              req_data_hi;
    logic              wr_stall;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              drop_pulse;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        output req_valid, req_idx, req_data, req_idx_hi, req_data_hi, wr_stall,
        input  req_ready, wr_en, wr_idx, wr_data, drop_pulse, drop_cnt
    );

    modport slave (
        input  req_valid, req_idx, req_data, req_idx_hi, req_data_hi, wr_stall,
        output req_ready, wr_en, wr_idx, wr_data, drop_pulse, drop_cnt
    );
endinterface

// File: rtl/sec_array_wr_stage.sv
// Write-request staging FIFO in front of a Low-labelled array: High-tainted requests
// are consumed and counted but never enqueued; clean ones issue one write per cycle.
module sec_array_wr_stage #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 2,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input logic                 clk,
    input logic                 reset,
    sec_array_wr_stage_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [IDX_W-1:0]  idx_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [OCC_W-1:0]  count;

    logic accept_p0;
    logic taint_p0;
    logic push_p0;
    logic pop_p0;

    logic              vld_p1;
    logic [IDX_W-1:0]  idx_p1;
    logic [DATA_W-1:0] data_p1;
    logic              drop_p1;
    logic [CNT_W-1:0]  drop_cnt_p1;

    // Stage 0: handshake, taint filter and FIFO bookkeeping (ready depends on count only)
    assign bus.req_ready = (count != FULL);
    assign accept_p0     = bus.req_valid && bus.req_ready;
    assign taint_p0      = bus.req_idx_hi || bus.req_data_hi;
    assign push_p0       = accept_p0 && !taint_p0;
    assign pop_p0        = !bus.wr_stall && (count != '0);

    always_ff @(posedge clk) begin
        if (push_p0) begin
            idx_mem[wptr]  <= bus.req_idx;
            data_mem[wptr] <= bus.req_data;
        end
    end

    // Stage 1: registered array write port and drop reporting
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            vld_p1      <= 1'b0;
            idx_p1      <= '0;
            data_p1     <= '0;
            drop_p1     <= 1'b0;
            drop_cnt_p1 <= '0;
        end else begin
            if (push_p0) wptr <= wptr + 1'b1;
            // Pop always reads the pre-edge head, so a same-edge push is never bypassed.
            if (pop_p0) begin
                rptr    <= rptr + 1'b1;
                vld_p1  <= 1'b1;
                idx_p1  <= idx_mem[rptr];
                data_p1 <= data_mem[rptr];
            end else begin
                vld_p1  <= 1'b0;
                idx_p1  <= '0;
                data_p1 <= '0;
            end
            case ({push_p0, pop_p0})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            drop_p1 <= accept_p0 && taint_p0;
            if (accept_p0 && taint_p0) drop_cnt_p1 <= sat_inc(drop_cnt_p1);
        end
    end

    assign bus.wr_en      = vld_p1;
    assign bus.wr_idx     = idx_p1;
    assign bus.wr_data    = data_p1;
    assign bus.drop_pulse = drop_p1;
    assign bus.drop_cnt   = drop_cnt_p1;
endmodule

// File: tb/tb_sec_array_wr_stage.sv
// Randomized bench for sec_array_wr_stage: a queue-based reference model predicts every
// write and drop; a second instance with a 2-bit counter shares the stimulus.
module tb_sec_array_wr_stage;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 2;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sec_array_wr_stage_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(8)) bus ();
    sec_array_wr_stage_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(2)) bus_s ();

    assign bus_s.req_valid   = bus.req_valid;
    assign bus_s.req_idx     = bus.req_idx;
    assign bus_s.req_data    = bus.req_data;
    assign bus_s.req_idx_hi  = bus.req_idx_hi;
    assign bus_s.req_data_hi = bus.req_data_hi;
    assign bus_s.wr_stall    = bus.wr_stall;

    sec_array_wr_stage #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    sec_array_wr_stage #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus_s.slave));

    int checks = 0;
    int errors = 0;
    int ncyc = 0;

    // Reference model: queue of pending clean writes plus expected registered outputs.
    logic [IDX_W+DATA_W-1:0] mq[$];
    int                m_drops = 0;
    bit                last_acc = 0;
    logic              exp_wr_en = 0;
    logic [IDX_W-1:0]  exp_wr_idx = '0;
    logic [DATA_W-1:0] exp_wr_data = '0;
    logic              exp_drop_pulse = 0;
    logic [7:0]        exp_cnt8;
    logic [1:0]        exp_cnt2;

    always_comb begin
        exp_cnt8 = (m_drops > 255) ? 8'd255 : 8'(m_drops);
        exp_cnt2 = (m_drops > 3) ? 2'd3 : 2'(m_drops);
    end

    task automatic cycle();
        logic [IDX_W+DATA_W-1:0] head;
        bit pop;
        last_acc = 0;
        if (!reset) begin
            mq.delete();
            m_drops = 0;
            exp_wr_en = 0; exp_wr_idx = '0; exp_wr_data = '0; exp_drop_pulse = 0;
        end else begin
            last_acc = bus.req_valid && (mq.size() != DEPTH);
            pop = !bus.wr_stall && (mq.size() > 0);
            exp_wr_en = 0; exp_wr_idx = '0; exp_wr_data = '0; exp_drop_pulse = 0;
            if (pop) begin
                head = mq.pop_front();
                exp_wr_en = 1;
                {exp_wr_idx, exp_wr_data} = head;
            end
            if (last_acc) begin
                if (bus.req_idx_hi || bus.req_data_hi) begin
                    exp_drop_pulse = 1;
                    m_drops++;
                end else begin
                    mq.push_back({bus.req_idx, bus.req_data});
                end
            end
        end
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic drive(input logic v, input logic [IDX_W-1:0] i, input logic [DATA_W-1:0] d,
                         input logic ih, input logic dh);
        bus.req_valid = v; bus.req_idx = i; bus.req_data = d;
        bus.req_idx_hi = ih; bus.req_data_hi = dh;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.wr_stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, IDX_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
            cycle();
            checks++;
            if (bus.wr_en !== 1'b0 || bus.drop_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold: wr_en=%b drop_cnt=%0d, required wr_en=0 drop_cnt=0", bus.wr_en, bus.drop_cnt);
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cycle();
            checks++;
            if (bus.wr_en !== 1'b0 || bus.req_ready !== 1'b1 || bus.drop_cnt !== 8'd0 ||
                bus.wr_idx !== '0 || bus.wr_data !== '0 || bus.drop_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_release: wr_en=%b ready=%b drop_cnt=%0d idx=%0d data=%h pulse=%b, required 0 1 0 0 0000 0",
                         bus.wr_en, bus.req_ready, bus.drop_cnt, bus.wr_idx, bus.wr_data, bus.drop_pulse);
            end
        end
    endtask

    task automatic test_single_write();
        drive(1'b1, 2'd2, 16'hBEEF, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: wr_en=%b after accept edge, required 0", bus.wr_en);
        end
        cycle();
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_idx !== 2'd2 || bus.wr_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_write: wr_en=%b idx=%0d data=%h, required 1 2 beef", bus.wr_en, bus.wr_idx, bus.wr_data);
        end
        cycle();
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_idx !== '0 || bus.wr_data !== '0) begin
            errors++;
            $display("FAIL single_clear: wr_en=%b idx=%0d data=%h, required 0 0 0000", bus.wr_en, bus.wr_idx, bus.wr_data);
        end
    endtask

    task automatic test_filter();
        int pulses = 0;
        int wrs = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, IDX_W'($urandom), DATA_W'($urandom), (k % 3) != 1, (k % 3) != 0);
            cycle();
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            if (bus.drop_pulse === 1'b1) pulses++;
            if (bus.wr_en !== 1'b0) wrs++;
            cycle();
            if (bus.drop_pulse !== 1'b0) pulses += 100;
            if (bus.wr_en !== 1'b0) wrs++;
            if (k == 2) begin
                checks++;
                if (pulses !== 3 || bus.drop_cnt !== 8'd3) begin
                    errors++;
                    $display("FAIL filter_three: pulses=%0d drop_cnt=%0d, required 3 3", pulses, bus.drop_cnt);
                end
            end
        end
        checks++;
        if (wrs !== 0) begin
            errors++;
            $display("FAIL filter_no_write: tainted writes=%0d, required 0", wrs);
        end
        checks++;
        if (bus.drop_cnt !== 8'd5 || bus_s.drop_cnt !== 2'd3 || bus.drop_cnt !== exp_cnt8) begin
            errors++;
            $display("FAIL filter_saturate: cnt8=%0d cnt2=%0d, required 5 3", bus.drop_cnt, bus_s.drop_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] d[3];
        int k = 0;
        int got[$];
        int first = -1;
        int last = -1;
        for (int i = 0; i < 3; i++) d[i] = DATA_W'($urandom);
        bus.wr_stall = 1'b1;
        drive(1'b1, 2'd0, d[0], 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (last_acc) k++;
            if (k < 3) drive(1'b1, IDX_W'(k), d[k], 1'b0, 1'b0);
            else drive(1'b0, '0, '0, 1'b0, 1'b0);
            checks++;
            if (bus.wr_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_no_write: wr_en=%b under stall, required 0", bus.wr_en);
            end
        end
        checks++;
        if (k !== 2 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_full: accepted=%0d ready=%b, required 2 0", k, bus.req_ready);
        end
        bus.wr_stall = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (last_acc) k++;
            if (k < 3) drive(1'b1, IDX_W'(k), d[k], 1'b0, 1'b0);
            else drive(1'b0, '0, '0, 1'b0, 1'b0);
            checks++;
            if (bus.wr_en !== exp_wr_en || bus.wr_idx !== exp_wr_idx || bus.wr_data !== exp_wr_data) begin
                errors++;
                $display("FAIL bp_drain: en=%b idx=%0d data=%h, required %b %0d %h",
                         bus.wr_en, bus.wr_idx, bus.wr_data, exp_wr_en, exp_wr_idx, exp_wr_data);
            end
            if (bus.wr_en === 1'b1) begin
                got.push_back(int'(bus.wr_idx));
                if (first < 0) first = ncyc;
                last = ncyc;
                checks++;
                if (bus.wr_data !== d[got.size()-1]) begin
                    errors++;
                    $display("FAIL bp_data: data=%h, required %h", bus.wr_data, d[got.size()-1]);
                end
            end
        end
        checks++;
        if (got.size() != 3 || got[0] != 0 || got[1] != 1 || got[2] != 2 || last - first != 2) begin
            errors++;
            $display("FAIL bp_order: writes=%0d span=%0d, required 3 writes idx 0,1,2 on consecutive cycles",
                     got.size(), last - first);
        end
    endtask

    task automatic test_streaming();
        logic [DATA_W-1:0] d[20];
        int k = 0;
        int nw = 0;
        int first = -1;
        int last = -1;
        for (int i = 0; i < 20; i++) d[i] = DATA_W'($urandom);
        bus.wr_stall = 1'b0;
        drive(1'b1, 2'd0, d[0], 1'b0, 1'b0);
        for (int c = 0; c < 60 && nw < 20; c++) begin
            cycle();
            if (last_acc) k++;
            if (k < 20) drive(1'b1, IDX_W'(k % 4), d[k], 1'b0, 1'b0);
            else drive(1'b0, '0, '0, 1'b0, 1'b0);
            if (bus.wr_en === 1'b1) begin
                checks++;
                if (bus.wr_idx !== IDX_W'(nw % 4) || bus.wr_data !== d[nw]) begin
                    errors++;
                    $display("FAIL stream_write: #%0d idx=%0d data=%h, required %0d %h",
                             nw, bus.wr_idx, bus.wr_data, nw % 4, d[nw]);
                end
                if (first < 0) first = ncyc;
                last = ncyc;
                nw++;
            end
        end
        checks++;
        if (nw != 20 || last - first != 19) begin
            errors++;
            $display("FAIL stream_rate: writes=%0d span=%0d, required 20 19", nw, last - first);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            if (!(bus.req_valid && !last_acc))
                drive($urandom_range(0, 3) != 0, IDX_W'($urandom), DATA_W'($urandom),
                      $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            bus.wr_stall = ($urandom_range(0, 2) == 0);
            cycle();
            checks++;
            if (bus.wr_en !== exp_wr_en || bus.wr_idx !== exp_wr_idx || bus.wr_data !== exp_wr_data ||
                bus.drop_pulse !== exp_drop_pulse || bus.drop_cnt !== exp_cnt8 ||
                bus_s.drop_cnt !== exp_cnt2 || bus.req_ready !== (mq.size() != DEPTH)) begin
                errors++;
                $display("FAIL random_cycle %0d: en=%b idx=%0d data=%h pulse=%b cnt=%0d cnt2=%0d rdy=%b, required %b %0d %h %b %0d %0d %b",
                         c, bus.wr_en, bus.wr_idx, bus.wr_data, bus.drop_pulse, bus.drop_cnt, bus_s.drop_cnt,
                         bus.req_ready, exp_wr_en, exp_wr_idx, exp_wr_data, exp_drop_pulse, exp_cnt8, exp_cnt2,
                         mq.size() != DEPTH);
            end
        end
    endtask

    task automatic test_mid_reset();
        int k = 0;
        int stray = 0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.wr_stall = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        bus.wr_stall = 1'b1;
        drive(1'b1, 2'd1, DATA_W'($urandom), 1'b0, 1'b0);
        for (int c = 0; c < 6 && k < 2; c++) begin
            cycle();
            if (last_acc) begin
                k++;
                drive(1'b1, 2'd3, DATA_W'($urandom), 1'b0, 1'b0);
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (k != 2 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_fill: accepted=%0d ready=%b, required 2 0", k, bus.req_ready);
        end
        reset = 1'b0;
        bus.wr_stall = 1'b0;
        cycle();
        reset = 1'b1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.drop_cnt !== 8'd0 || bus_s.drop_cnt !== 2'd0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state: en=%b cnt=%0d cnt2=%0d rdy=%b, required 0 0 0 1",
                     bus.wr_en, bus.drop_cnt, bus_s.drop_cnt, bus.req_ready);
        end
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (bus.wr_en !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0 || bus.drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midrst_discard: stray writes=%0d drop_cnt=%0d, required 0 0", stray, bus.drop_cnt);
        end
    endtask

    initial begin
        bus.wr_stall = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        test_reset();
        test_single_write();
        test_filter();
        test_backpressure();
        test_streaming();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/sec_array_wr_stage.md
Name: sec_array_wr_stage

Overview:
- Write-request staging stage directly upstream of a labelled storage array (4 x 16-bit entries, label L).
- Accepts indexed write requests over a valid/ready handshake and buffers them in a small in-order FIFO.
- Filters out any request whose index or data is tainted High, so a High value never reaches the array's Low-labelled write port.
- Issues clean writes as a registered one-write-per-cycle port with stall backpressure, and counts dropped requests.

Parameters:
- DATA_W, 16: width of write data.
- IDX_W, 2: width of array index (array depth 2**IDX_W).
- DEPTH, 2: FIFO entries; must be a power of 2, >= 2.
- CNT_W, 8: width of the drop counter.

Ports:
- clk  in  1  clock, label L.
- reset  in  1  synchronous, active-low reset (0 = reset), label L.
- req_valid  in  1  upstream request valid, L.
- req_ready  out  1  stage can accept a request, L.
- req_idx  in  IDX_W  target array index, L.
- req_data  in  DATA_W  write data, L.
- req_idx_hi  in  1  1 = index derived from High data, L.
- req_data_hi  in  1  1 = data derived from High data, L.
- wr_stall  in  1  array cannot take a write this cycle, L.
- wr_en  out  1  write strobe to array, L.
- wr_idx  out  IDX_W  write index to array, L.
- wr_data  out  DATA_W  write data to array, L.
- drop_pulse  out  1  one-cycle pulse per filtered request, L.
- drop_cnt  out  CNT_W  saturating count of filtered requests, L.

Behaviour:
- Reset, sampled on posedge clk with reset==0:
  - FIFO empty; read/write pointers and count = 0.
  - Outputs: wr_en=0, wr_idx=0, wr_data=0, drop_pulse=0, drop_cnt=0.
  - Reset mid-operation discards all buffered requests. No write is issued on the reset edge or the edge after it.
- req_ready = (count != DEPTH).
  - Driven only from registered state. No combinational path from req_valid, wr_stall or req_* to req_ready.
- Handshake: a request is accepted on an edge where req_valid && req_ready.
  - Upstream must hold req_* stable while req_valid is high and req_ready is low.
- Filter, applied at acceptance:
  - If req_idx_hi or req_data_hi is set:
    - The request is consumed but not enqueued.
    - drop_pulse=1 for the following cycle.
    - drop_cnt increments and saturates at 2**CNT_W-1 with no wrap.
  - Otherwise {req_idx, req_data} is pushed at the write pointer.
  - A dropped request never changes wr_idx, wr_data or FIFO contents.
- Issue, on each edge out of reset:
  - If !wr_stall and count>0: pop the head into the output registers and set wr_en=1.
  - Otherwise: wr_en=0, wr_idx=0, wr_data=0. Outputs are cleared, not held, whenever idle.
- Latency: a clean request accepted at edge N into an empty FIFO appears with wr_en=1 after edge N+1, given no stall. Throughput is 1 write per cycle.
- Simultaneous push and pop on the same edge: count is unchanged and both pointers advance.
  - The pop takes the old head. A same-edge push is never bypassed to the output.
- Pointers wrap modulo DEPTH. Ordering is strictly FIFO, so write-after-write to the same index is preserved.
- Stall: while wr_stall=1, no pop and buffered entries hold. Pushes continue until full, then req_ready=0.
- A dropped request on a cycle when the FIFO is full is impossible, because req_ready=0 blocks it.

Test Plan:
- Reset hold: reset=0 for 3 cycles with req_valid=1 -> wr_en=0, req_ready=1, drop_cnt=0 after release; no write from pre-release requests.
- Clean single write: idx=2, data=16'hBEEF accepted at edge N -> wr_en=1, wr_idx=2, wr_data=16'hBEEF for exactly 1 cycle after edge N+1, then all outputs 0.
- Filter: three requests with idx_hi=1 / data_hi=1 / both -> no wr_en ever; drop_pulse seen 3 times; drop_cnt=3. Saturation check with CNT_W=2: 5 drops -> drop_cnt=3.
- Backpressure: wr_stall=1, push idx 0,1,2 -> req_ready=0 after 2 accepts, third held. Release stall -> writes 0,1,2 issued in order on consecutive cycles.
- Streaming: continuous valid requests with idx 0..3 wrapping, no stall, 20 requests -> 20 writes in order, 1 per cycle after initial latency; pointer wrap exercised.
- Mid-operation reset: 2 entries buffered under stall, assert reset for 1 cycle -> FIFO empty, no buffered write ever issued, drop_cnt=0.
